seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 100000, meaning clock cycles each digit stays lit (legal range 2 or more).
REQ-002 Parameter BLINK_DIV, default 250, meaning full 4-digit scan frames per blink half-period (legal range 1 or more).
REQ-003 Port clk, input, 1 bit, meaning the single system clock; all state is updated on its rising edge.
REQ-004 Port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-005 Port min_first, input, 4 bits, meaning BCD minute units digit from the minute setter.
REQ-006 Port min_second, input, 4 bits, meaning BCD minute tens digit from the minute setter.
REQ-007 Port hour_first and hour_second, input, 4 bits each, meaning BCD hour units and hour tens digits.
REQ-008 Port mode_setcurrent, input, 1 bit, meaning 1 while minutes are being set, which enables minute blinking.
REQ-009 Port an, output, 4 bits, meaning active-low digit enables; an[0] is the rightmost digit.
REQ-010 Port seg, output, 7 bits, meaning active-low segments in order {g,f,e,d,c,b,a}.
REQ-011 Port dp, output, 1 bit, meaning active-low colon/decimal point.

Function
REQ-012 The prescaler shall count 0 to SCAN_DIV-1 and then wrap to 0; the wrap cycle is the scan tick.
REQ-013 On each scan tick the 2-bit digit index shall advance 0->1->2->3->0.
REQ-014 Index 0 shall select min_first, 1 min_second, 2 hour_first, and 3 hour_second.
REQ-015 an, seg and dp shall be registered and shall reflect a new index exactly 1 clock after the index changes.
REQ-016 an shall be all ones except for a 0 at the bit matching the index.
REQ-017 The BCD-to-segment map for 0-9 shall be the standard map, e.g. 0 -> 7'b1000000, 8 -> 7'b0000000.
REQ-018 Any input value of 10-15 shall display a dash (seg = 7'b0111111).
REQ-019 The frame counter shall increment on each scan tick where the index wraps 3->0, counting 0 to BLINK_DIV-1.
REQ-020 When the frame counter wraps, blink_phase shall toggle.
REQ-021 While mode_setcurrent=1 and blink_phase=1, digits 0 and 1 shall be blanked: an bit held at 1 and seg=7'h7F. Hour digits are unaffected.
REQ-022 Hour tens equal to 0 shall be blanked (leading-zero suppression).
REQ-023 dp shall be 0 only while digit 2 is active, and shall be 1 otherwise.
REQ-024 Digit inputs shall be sampled in the same cycle the output register loads, so an input change becomes visible no later than the next time that digit is selected.
REQ-025 A change on mode_setcurrent shall not reset the counters; blanking shall take effect on the next output register load.
REQ-026 At no time shall more than one an bit be 0.

Reset
REQ-027 While rst_n=0 (asynchronous): an=4'b1111, seg=7'h7F, dp=1, prescaler=0, index=0, frame counter=0, blink_phase=0.
REQ-028 After rst_n rises, the first output load shall display digit 0; reset asserted mid-frame shall restart scanning from digit 0.

Structure
REQ-029 A shared package shall hold the segment constants (SEG_BLANK, SEG_DASH, and the 0-9 patterns) and the digit-index typedef.
REQ-030 A combinational sub-module bcd_to_seg (4-bit in, 7-bit active-low out) shall implement REQ-017 and REQ-018, instantiated once.

Verification (SCAN_DIV=4, BLINK_DIV=2)
REQ-031 Reset release with mins 37 and hours 12 -> an cycles 1110,1101,1011,0111 with 4 clocks each, seg showing 7,3,2,1, and dp=0 only on an=1011.
REQ-032 min_first=4'hC -> seg=7'b0111111 whenever an=1110.
REQ-033 hour_second=0 -> an=0111 slot shows seg=7'h7F; hour_first is still shown.
REQ-034 mode_setcurrent=1 -> minute digits are shown for 2 frames (32 clocks), then blanked for 2 frames, repeating; hour digits are always shown.
REQ-035 rst_n pulsed low during digit 2 -> outputs go to reset values immediately; after release, scanning restarts at an=1110.
REQ-036 All runs -> assertion that an is never anything but 1111 or one-hot-low.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the multiplexed 4-digit seven-segment driver.
// Holds the active-low segment patterns, in {g,f,e,d,c,b,a} order, and the digit-index type.
package seg_scan_driver_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t DIG_MIN_ONES  = 2'd0;
  localparam digit_idx_t DIG_MIN_TENS  = 2'd1;
  localparam digit_idx_t DIG_HOUR_ONES = 2'd2;
  localparam digit_idx_t DIG_HOUR_TENS = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// Combinational BCD to seven-segment decoder.
// Ports: bcd (4-bit digit in), seg (7-bit active-low {g,f,e,d,c,b,a} out).
// Non-BCD codes 10-15 decode to a dash.
module bcd_to_seg
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit clock display (MM on the right, HH on the left).
// Ports:
//   clk, rst_n                    system clock, async active-low reset
//   min_first/min_second          BCD minute units/tens
//   hour_first/hour_second        BCD hour units/tens
//   mode_setcurrent               1 while minutes are being set (minute digits blink)
//   an                            active-low digit enables, an[0] = rightmost
//   seg                           active-low segments {g,f,e,d,c,b,a}
//   dp                            active-low colon, lit with the hour-units digit
// Each digit stays lit for SCAN_DIV clocks; blink phase toggles every BLINK_DIV full frames.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] min_first,
  input  logic [3:0] min_second,
  input  logic [3:0] hour_first,
  input  logic [3:0] hour_second,
  input  logic       mode_setcurrent,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FR_LAST = FW'(BLINK_DIV - 1);

  logic [PW-1:0] prescale;
  logic [FW-1:0] frame;
  digit_idx_t    idx;
  logic          blink_phase;
  logic          scan_tick;

  logic [3:0] digit_val;
  logic [6:0] seg_raw;
  logic       blank_min;
  logic       lead_zero;
  logic [3:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  assign scan_tick = (prescale == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale    <= '0;
      idx         <= DIG_MIN_ONES;
      frame       <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (scan_tick) begin
        prescale <= '0;
        idx      <= idx + 2'd1;
        // A frame ends when the last digit hands back to digit 0.
        if (idx == DIG_HOUR_TENS) begin
          if (frame == FR_LAST) begin
            frame       <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            frame <= frame + 1'b1;
          end
        end
      end else begin
        prescale <= prescale + 1'b1;
      end
    end
  end

  always_comb begin
    digit_val = min_first;
    case (idx)
      DIG_MIN_ONES:  digit_val = min_first;
      DIG_MIN_TENS:  digit_val = min_second;
      DIG_HOUR_ONES: digit_val = hour_first;
      DIG_HOUR_TENS: digit_val = hour_second;
      default:       digit_val = min_first;
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd (digit_val),
    .seg (seg_raw)
  );

  // Minute digits (index 0/1) go dark entirely during the off half of the blink.
  // Hour-tens zero blanks segments only; its enable still follows the scan.
  always_comb begin
    blank_min = mode_setcurrent && blink_phase && !idx[1];
    lead_zero = (idx == DIG_HOUR_TENS) && (hour_second == 4'd0);
    an_next   = blank_min ? 4'hF : ~(4'b0001 << idx);
    seg_next  = (blank_min || lead_zero) ? SEG_BLANK : seg_raw;
    dp_next   = (idx != DIG_HOUR_ONES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'hF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, BLINK_DIV=2.
// Expected outputs come from the clock count since reset release:
// output after edge n shows digit ((n-1)/4)%4, minute digits blanked when mode=1 and ((n-1)/32) is odd.
module tb_seg_scan_driver;

  logic       clk;
  logic       rst_n;
  logic [3:0] min_first, min_second, hour_first, hour_second;
  logic       mode_setcurrent;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_errors = 0;
  int n_edge   = 0;

  seg_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .min_first       (min_first),
    .min_second      (min_second),
    .hour_first      (hour_first),
    .hour_second     (hour_second),
    .mode_setcurrent (mode_setcurrent),
    .an              (an),
    .seg             (seg),
    .dp              (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic run_cycles(input int num, input string tag);
    int d;
    logic blank;
    logic [3:0] v, e_an;
    logic [6:0] e_seg;
    logic e_dp;
    for (int i = 0; i < num; i++) begin
      @(posedge clk);
      n_edge++;
      @(negedge clk);
      d = ((n_edge - 1) / 4) % 4;
      blank = mode_setcurrent && ((((n_edge - 1) / 32) % 2) == 1) && (d < 2);
      case (d)
        0: v = min_first;
        1: v = min_second;
        2: v = hour_first;
        default: v = hour_second;
      endcase
      e_an  = blank ? 4'b1111 : (d == 0 ? 4'b1110 : d == 1 ? 4'b1101 : d == 2 ? 4'b1011 : 4'b0111);
      e_seg = (blank || (d == 3 && v == 4'd0)) ? 7'h7F : seg_of(v);
      e_dp  = (d == 2) ? 1'b0 : 1'b1;
      check_val($sformatf("%s_an@%0d", tag, n_edge), {28'd0, an}, {28'd0, e_an});
      check_val($sformatf("%s_seg@%0d", tag, n_edge), {25'd0, seg}, {25'd0, e_seg});
      check_val($sformatf("%s_dp@%0d", tag, n_edge), {31'd0, dp}, {31'd0, e_dp});
    end
  endtask

  always @(negedge clk) begin
    check_val("an_onehot", {31'd0, (an == 4'hF) || $onehot(~an)}, 32'd1);
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    min_first = 4'd7; min_second = 4'd3; hour_first = 4'd2; hour_second = 4'd1;
    mode_setcurrent = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_an", {28'd0, an}, 32'h0000000F);
    check_val("rst_seg", {25'd0, seg}, 32'h0000007F);
    check_val("rst_dp", {31'd0, dp}, 32'd1);

    rst_n = 1'b1;
    n_edge = 0;
    run_cycles(32, "scan37_12");

    min_first = 4'hC;
    run_cycles(16, "dash");

    min_first = 4'd7; hour_second = 4'd0;
    run_cycles(16, "lead_zero");

    hour_second = 4'd1; mode_setcurrent = 1'b1;
    run_cycles(96, "blink");

    mode_setcurrent = 1'b0;
    run_cycles(12, "pre_rst");
    check_val("pre_rst_digit2", {28'd0, an}, 32'h0000000B);

    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_an", {28'd0, an}, 32'h0000000F);
    check_val("midrst_seg", {25'd0, seg}, 32'h0000007F);
    check_val("midrst_dp", {31'd0, dp}, 32'd1);
    @(posedge clk);
    #1;
    check_val("midrst_hold_an", {28'd0, an}, 32'h0000000F);
    @(negedge clk);
    rst_n = 1'b1;
    n_edge = 0;
    min_second = 4'd5;
    run_cycles(20, "restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end

endmodule
